// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- control FSM for a multi-cycle RV32-style datapath.
//
// Sequences FETCH -> DECODE -> EXECUTE -> [MEM] -> [WRITEBACK] for the
// supported base opcodes. It produces datapath strobes and selects that are
// decoded from the current state and the opcode latched in DECODE (op_q).
// Unsupported opcodes and data-memory timeouts park the FSM in HALT with a
// sticky flag. Only reset leaves HALT.
//
// Ports:
//   i_clk            single clock, rising edge
//   i_reset          synchronous active-low reset
//   i_run            start request, sampled in IDLE
//   i_halt_req       stop request, honoured at instruction end
//   i_opcode[6:0]    opcode from decoder, latched in DECODE
//   i_zero_flag      ALU zero result (branch resolution)
//   i_mem_ready      data memory access complete
//   o_ir_we, o_pc_we, o_reg_we, o_mem_rd, o_mem_wr, o_alu_src  strobes/selects
//   o_pc_sel[1:0]     0=PC+4, 1=branch target, 2=jump target
//   o_mem_to_reg[1:0] 0=ALU, 1=memory data, 2=PC+4
//   o_alu_op[2:0]     0=add, 1=sub/compare, 2=R funct, 3=I funct
//   o_state[2:0]      current FSM state
//   o_busy            high outside IDLE and HALT
//   o_illegal         sticky: unsupported opcode seen
//   o_mem_err         sticky: memory access timed out
//
// Optional feature (macro CTRL_PERF_CNT_EN):
//   o_cycle_cnt[31:0]  busy cycles, wraps
//   o_retire_cnt[31:0] pc_we cycles, wraps
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_run,
  input  logic       i_halt_req,
  input  logic [6:0] i_opcode,
  input  logic       i_zero_flag,
  input  logic       i_mem_ready,
  output logic       o_ir_we,
  output logic       o_pc_we,
  output logic       o_reg_we,
  output logic       o_mem_rd,
  output logic       o_mem_wr,
  output logic       o_alu_src,
  output logic [1:0] o_pc_sel,
  output logic [1:0] o_mem_to_reg,
  output logic [2:0] o_alu_op,
  output logic [2:0] o_state,
  output logic       o_busy,
  output logic       o_illegal,
  output logic       o_mem_err
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0] o_cycle_cnt,
  output logic [31:0] o_retire_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // The counter holds the number of waiting cycles already spent in MEM.
  // The cycle in which it equals MEM_TIMEOUT-1 is the last allowed wait.
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  function automatic logic f_is_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR: f_is_legal = 1'b1;
      default:                                                  f_is_legal = 1'b0;
    endcase
  endfunction

  state_t     r_state;
  state_t     w_next_state;
  state_t     w_instr_end;
  logic [6:0] r_op_q;
  logic [7:0] r_tmo_cnt;
  logic       r_illegal;
  logic       r_mem_err;
  logic       w_set_illegal;
  logic       w_set_mem_err;
  logic       w_tmo_hit;

  assign w_tmo_hit = (r_tmo_cnt >= TMO_LAST);
  assign o_state   = r_state;
  assign o_busy    = (r_state != S_IDLE) && (r_state != S_HALT);
  assign o_illegal = r_illegal;
  assign o_mem_err = r_mem_err;

  // Successor state once an instruction finishes.
  always_comb begin
    w_instr_end = S_FETCH;
    if (i_halt_req) begin
      w_instr_end = S_IDLE;
    end else begin
      w_instr_end = S_FETCH;
    end
  end

  // Next-state logic and Moore-style decode of strobes/selects.
  always_comb begin
    w_next_state  = r_state;
    w_set_illegal = 1'b0;
    w_set_mem_err = 1'b0;
    o_ir_we       = 1'b0;
    o_pc_we       = 1'b0;
    o_reg_we      = 1'b0;
    o_mem_rd      = 1'b0;
    o_mem_wr      = 1'b0;
    o_alu_src     = 1'b0;
    o_pc_sel      = 2'd0;
    o_mem_to_reg  = 2'd0;
    o_alu_op      = 3'd0;
    case (r_state)
      S_IDLE: begin
        if (i_run && !i_halt_req) begin
          w_next_state = S_FETCH;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_FETCH: begin
        o_ir_we      = 1'b1;
        w_next_state = S_DECODE;
      end
      S_DECODE: begin
        // op_q is loaded on this edge, so the decision uses the live opcode.
        if (f_is_legal(i_opcode)) begin
          w_next_state = S_EXECUTE;
        end else begin
          w_next_state  = S_HALT;
          w_set_illegal = 1'b1;
        end
      end
      S_EXECUTE: begin
        case (r_op_q)
          OP_I: begin
            o_alu_src    = 1'b1;
            o_alu_op     = 3'd3;
            w_next_state = S_WRITEBACK;
          end
          OP_R: begin
            o_alu_op     = 3'd2;
            w_next_state = S_WRITEBACK;
          end
          OP_BRANCH: begin
            o_alu_op     = 3'd1;
            o_pc_we      = 1'b1;
            o_pc_sel     = i_zero_flag ? 2'd1 : 2'd0;
            w_next_state = w_instr_end;
          end
          OP_LOAD, OP_STORE: begin
            o_alu_src    = 1'b1;
            w_next_state = S_MEM;
          end
          OP_JALR: begin
            o_alu_src    = 1'b1;
            w_next_state = S_WRITEBACK;
          end
          default: begin
            // JAL: address add only.
            w_next_state = S_WRITEBACK;
          end
        endcase
      end
      S_MEM: begin
        if (r_op_q == OP_LOAD) begin
          o_mem_rd = 1'b1;
        end else begin
          o_mem_wr = 1'b1;
        end
        // A ready in the timeout cycle still completes the access.
        if (i_mem_ready) begin
          if (r_op_q == OP_LOAD) begin
            w_next_state = S_WRITEBACK;
          end else begin
            o_pc_we      = 1'b1;
            w_next_state = w_instr_end;
          end
        end else if (w_tmo_hit) begin
          w_next_state  = S_HALT;
          w_set_mem_err = 1'b1;
        end else begin
          w_next_state = S_MEM;
        end
      end
      S_WRITEBACK: begin
        o_reg_we = 1'b1;
        o_pc_we  = 1'b1;
        if (r_op_q == OP_LOAD) begin
          o_mem_to_reg = 2'd1;
        end else if ((r_op_q == OP_JAL) || (r_op_q == OP_JALR)) begin
          o_mem_to_reg = 2'd2;
          o_pc_sel     = 2'd2;
        end else begin
          o_mem_to_reg = 2'd0;
        end
        w_next_state = w_instr_end;
      end
      S_HALT: begin
        w_next_state = S_HALT;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State, latched opcode, MEM wait counter and sticky fault flags.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state   <= S_IDLE;
      r_op_q    <= 7'd0;
      r_tmo_cnt <= 8'd0;
      r_illegal <= 1'b0;
      r_mem_err <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_DECODE) begin
        r_op_q <= i_opcode;
      end
      // Counter is held at zero outside MEM, so it restarts on each entry.
      if (r_state != S_MEM) begin
        r_tmo_cnt <= 8'd0;
      end else if (!i_mem_ready) begin
        r_tmo_cnt <= r_tmo_cnt + 8'd1;
      end
      if (w_set_illegal) begin
        r_illegal <= 1'b1;
      end
      if (w_set_mem_err) begin
        r_mem_err <= 1'b1;
      end
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_retire_cnt;

  assign o_cycle_cnt  = r_cycle_cnt;
  assign o_retire_cnt = r_retire_cnt;

  // Free-running busy-cycle and retirement counters; natural 32-bit wrap.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_cycle_cnt  <= 32'd0;
      r_retire_cnt <= 32'd0;
    end else begin
      if (o_busy) begin
        r_cycle_cnt <= r_cycle_cnt + 32'd1;
      end
      if (o_pc_we) begin
        r_retire_cnt <= r_retire_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl (default build, MEM_TIMEOUT=15).
// Inputs for a cycle are applied 1 time unit after the rising edge and the
// outputs are sampled 1 time unit later.
// Strobe word layout:
//   {ir_we, pc_we, reg_we, mem_rd, mem_wr, alu_src, pc_sel[1:0], mem_to_reg[1:0], alu_op[2:0]}
module tb_multicycle_ctrl;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic clk, i_reset, i_run, i_halt_req, i_zero_flag, i_mem_ready;
  logic [6:0] i_opcode;
  logic o_ir_we, o_pc_we, o_reg_we, o_mem_rd, o_mem_wr, o_alu_src;
  logic [1:0] o_pc_sel, o_mem_to_reg;
  logic [2:0] o_alu_op, o_state;
  logic o_busy, o_illegal, o_mem_err;
  logic [12:0] strb;
  int checks = 0;
  int errors = 0;

  assign strb = {o_ir_we, o_pc_we, o_reg_we, o_mem_rd, o_mem_wr, o_alu_src,
                 o_pc_sel, o_mem_to_reg, o_alu_op};

  multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_run(i_run), .i_halt_req(i_halt_req),
    .i_opcode(i_opcode), .i_zero_flag(i_zero_flag), .i_mem_ready(i_mem_ready),
    .o_ir_we(o_ir_we), .o_pc_we(o_pc_we), .o_reg_we(o_reg_we), .o_mem_rd(o_mem_rd),
    .o_mem_wr(o_mem_wr), .o_alu_src(o_alu_src), .o_pc_sel(o_pc_sel),
    .o_mem_to_reg(o_mem_to_reg), .o_alu_op(o_alu_op), .o_state(o_state),
    .o_busy(o_busy), .o_illegal(o_illegal), .o_mem_err(o_mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset;
    i_reset = 1'b0; i_run = 1'b0; i_halt_req = 1'b0;
    i_zero_flag = 1'b0; i_mem_ready = 1'b0; i_opcode = 7'd0;
    repeat (2) @(posedge clk);
    #1;
    i_reset = 1'b1;
  endtask

  task automatic test_reset;
    i_reset = 1'b0; i_run = 1'b1; i_halt_req = 1'b0;
    i_zero_flag = 1'b0; i_mem_ready = 1'b0; i_opcode = OP_R;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #2;
      checks++;
      if (o_state !== 3'd0 || strb !== 13'h0000 || o_busy !== 1'b0 ||
          o_illegal !== 1'b0 || o_mem_err !== 1'b0) begin
        errors++;
        $display("FAIL reset cyc%0d state=%0d strb=%h busy=%b ill=%b merr=%b exp 0/0000/0/0/0",
                 k, o_state, strb, o_busy, o_illegal, o_mem_err);
      end
    end
    i_reset = 1'b1; i_run = 1'b0;
  endtask

  task automatic test_rtype;
    logic [2:0]  es [5] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd1};
    logic [12:0] eo [5] = '{13'h1000, 13'h0000, 13'h0002, 13'h0C00, 13'h1000};
    do_reset();
    i_opcode = OP_R; i_run = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #2;
      checks++;
      if (o_state !== es[k] || strb !== eo[k] || o_busy !== 1'b1) begin
        errors++;
        $display("FAIL rtype cyc%0d state=%0d strb=%h busy=%b exp state=%0d strb=%h busy=1",
                 k, o_state, strb, o_busy, es[k], eo[k]);
      end
    end
  endtask

  task automatic test_load;
    logic [2:0]  es [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd5, 3'd1};
    logic [12:0] eo [9] = '{13'h1000, 13'h0000, 13'h0080, 13'h0200, 13'h0200,
                            13'h0200, 13'h0200, 13'h0C08, 13'h1000};
    bit rdy [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    i_opcode = OP_LOAD; i_run = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      i_mem_ready = rdy[k];
      #1;
      checks++;
      if (o_state !== es[k] || strb !== eo[k]) begin
        errors++;
        $display("FAIL load cyc%0d state=%0d strb=%h exp state=%0d strb=%h",
                 k, o_state, strb, es[k], eo[k]);
      end
    end
  endtask

  task automatic test_branch;
    logic [2:0]  es [7] = '{3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd3, 3'd1};
    logic [12:0] eo [7] = '{13'h1000, 13'h0000, 13'h0821, 13'h1000,
                            13'h0000, 13'h0801, 13'h1000};
    bit zf [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    i_opcode = OP_BRANCH; i_run = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      i_zero_flag = zf[k];
      #1;
      checks++;
      if (o_state !== es[k] || strb !== eo[k]) begin
        errors++;
        $display("FAIL branch cyc%0d state=%0d strb=%h exp state=%0d strb=%h",
                 k, o_state, strb, es[k], eo[k]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0]  es [13] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd1, 3'd2, 3'd3, 3'd5,
                             3'd1, 3'd2, 3'd3, 3'd5, 3'd1};
    logic [12:0] eo [13] = '{13'h1000, 13'h0000, 13'h0083, 13'h0C00,
                             13'h1000, 13'h0000, 13'h0000, 13'h0C50,
                             13'h1000, 13'h0000, 13'h0080, 13'h0C50, 13'h1000};
    logic [6:0]  ops [13] = '{OP_I, OP_I, OP_I, OP_I, OP_JAL, OP_JAL, OP_JAL, OP_JAL,
                              OP_JALR, OP_JALR, OP_JALR, OP_JALR, OP_R};
    do_reset();
    i_opcode = OP_I; i_run = 1'b1;
    for (int k = 0; k < 13; k++) begin
      @(posedge clk); #1;
      i_opcode = ops[k];
      #1;
      checks++;
      if (o_state !== es[k] || strb !== eo[k]) begin
        errors++;
        $display("FAIL b2b cyc%0d state=%0d strb=%h exp state=%0d strb=%h",
                 k, o_state, strb, es[k], eo[k]);
      end
    end
  endtask

  task automatic test_illegal;
    logic [2:0] es [7] = '{3'd1, 3'd2, 3'd6, 3'd6, 3'd6, 3'd6, 3'd6};
    do_reset();
    i_opcode = 7'b0000000; i_run = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      i_run = (k % 2 == 0) ? 1'b0 : 1'b1;
      #1;
      checks++;
      if (o_state !== es[k] || o_illegal !== (k >= 2) || o_busy !== (k < 2) ||
          (k >= 2 && strb !== 13'h0000)) begin
        errors++;
        $display("FAIL illegal cyc%0d state=%0d ill=%b busy=%b strb=%h exp state=%0d ill=%b",
                 k, o_state, o_illegal, o_busy, strb, es[k], (k >= 2));
      end
    end
    i_reset = 1'b0;
    @(posedge clk); #2;
    checks++;
    if (o_state !== 3'd0 || o_illegal !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL illegal_clr state=%0d ill=%b busy=%b exp 0/0/0", o_state, o_illegal, o_busy);
    end
    i_reset = 1'b1;
  endtask

  // Immediate ready (4-cycle store), then ready arriving in the 15th MEM cycle.
  task automatic test_store;
    logic [2:0]  es4 [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1};
    logic [12:0] eo4 [5] = '{13'h1000, 13'h0000, 13'h0080, 13'h0900, 13'h1000};
    logic [2:0]  exp_s;
    logic [12:0] exp_o;
    do_reset();
    i_opcode = OP_STORE; i_run = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      i_mem_ready = (k == 3);
      #1;
      checks++;
      if (o_state !== es4[k] || strb !== eo4[k]) begin
        errors++;
        $display("FAIL store cyc%0d state=%0d strb=%h exp state=%0d strb=%h",
                 k, o_state, strb, es4[k], eo4[k]);
      end
    end
    do_reset();
    i_opcode = OP_STORE; i_run = 1'b1;
    for (int k = 0; k < 19; k++) begin
      @(posedge clk); #1;
      i_mem_ready = (k == 17);
      #1;
      if (k < 3) begin
        exp_s = es4[k]; exp_o = eo4[k];
      end else if (k < 18) begin
        exp_s = 3'd4; exp_o = (k == 17) ? 13'h0900 : 13'h0100;
      end else begin
        exp_s = 3'd1; exp_o = 13'h1000;
      end
      checks++;
      if (o_state !== exp_s || strb !== exp_o || o_mem_err !== 1'b0) begin
        errors++;
        $display("FAIL store_late cyc%0d state=%0d strb=%h merr=%b exp state=%0d strb=%h merr=0",
                 k, o_state, strb, o_mem_err, exp_s, exp_o);
      end
    end
  endtask

  task automatic test_mem_timeout;
    logic [2:0]  exp_s;
    logic [12:0] exp_o;
    do_reset();
    i_opcode = OP_STORE; i_run = 1'b1;
    for (int k = 0; k < 21; k++) begin
      @(posedge clk); #2;
      case (k)
        0:       begin exp_s = 3'd1; exp_o = 13'h1000; end
        1:       begin exp_s = 3'd2; exp_o = 13'h0000; end
        2:       begin exp_s = 3'd3; exp_o = 13'h0080; end
        default: begin
          exp_s = (k < 18) ? 3'd4 : 3'd6;
          exp_o = (k < 18) ? 13'h0100 : 13'h0000;
        end
      endcase
      checks++;
      if (o_state !== exp_s || strb !== exp_o || o_mem_err !== (k >= 18)) begin
        errors++;
        $display("FAIL timeout cyc%0d state=%0d strb=%h merr=%b exp state=%0d strb=%h merr=%b",
                 k, o_state, strb, o_mem_err, exp_s, exp_o, (k >= 18));
      end
    end
    // Reset clears the sticky error.
    i_reset = 1'b0;
    @(posedge clk); #2;
    checks++;
    if (o_state !== 3'd0 || o_mem_err !== 1'b0) begin
      errors++;
      $display("FAIL merr_clr state=%0d merr=%b exp 0/0", o_state, o_mem_err);
    end
    // Reset taken in the middle of a MEM wait.
    i_reset = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    checks++;
    if (o_state !== 3'd4 || o_mem_wr !== 1'b1) begin
      errors++;
      $display("FAIL midmem_pre state=%0d mem_wr=%b exp 4/1", o_state, o_mem_wr);
    end
    i_reset = 1'b0;
    @(posedge clk); #2;
    checks++;
    if (o_state !== 3'd0 || strb !== 13'h0000 || o_busy !== 1'b0 || o_mem_err !== 1'b0) begin
      errors++;
      $display("FAIL midmem_rst state=%0d strb=%h busy=%b merr=%b exp 0/0000/0/0",
               o_state, strb, o_busy, o_mem_err);
    end
    i_reset = 1'b1;
  endtask

  task automatic test_halt_req;
    logic [2:0]  es [7] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd0, 3'd0, 3'd1};
    logic [12:0] eo [7] = '{13'h1000, 13'h0000, 13'h0002, 13'h0C00,
                            13'h0000, 13'h0000, 13'h1000};
    bit hr [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    i_opcode = OP_R; i_run = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      i_halt_req = hr[k];
      #1;
      checks++;
      if (o_state !== es[k] || strb !== eo[k] || o_busy !== (es[k] != 3'd0)) begin
        errors++;
        $display("FAIL halt_req cyc%0d state=%0d strb=%h busy=%b exp state=%0d strb=%h",
                 k, o_state, strb, o_busy, es[k], eo[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load();
    test_branch();
    test_back_to_back();
    test_illegal();
    test_store();
    test_mem_timeout();
    test_halt_req();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
